// File: rtl/timer_pkg.sv
// Shared constants, state encoding and clamp helper for the HH:MM:SS countdown timer.
package timer_pkg;

  localparam int FIELD_W = 7;
  localparam logic [FIELD_W-1:0] SEC_MAX = 7'd59;
  localparam logic [FIELD_W-1:0] MIN_MAX = 7'd59;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_e;

  function automatic logic [FIELD_W-1:0] clamp_field(input logic [FIELD_W-1:0] value,
                                                     input logic [FIELD_W-1:0] limit);
    return (value > limit) ? limit : value;
  endfunction

endpackage

// File: rtl/hms_decrement.sv
// Combinational one-step HH:MM:SS borrow chain; a 00:00:00 input stays at zero.
module hms_decrement
  import timer_pkg::*;
(
  input  logic [FIELD_W-1:0] h,
  input  logic [FIELD_W-1:0] m,
  input  logic [FIELD_W-1:0] s,
  output logic [FIELD_W-1:0] h_next,
  output logic [FIELD_W-1:0] m_next,
  output logic [FIELD_W-1:0] s_next,
  output logic               is_zero
);

  always_comb begin
    h_next = h;
    m_next = m;
    s_next = s;
    if (s != '0) begin
      s_next = s - 7'd1;
    end else if (m != '0) begin
      m_next = m - 7'd1;
      s_next = SEC_MAX;
    end else if (h != '0) begin
      h_next = h - 7'd1;
      m_next = MIN_MAX;
      s_next = SEC_MAX;
    end
    is_zero = (h_next == '0) && (m_next == '0) && (s_next == '0);
  end

endmodule

// File: rtl/countdown_timer.sv
// HH:MM:SS countdown with expiry level/pulse. Optional auto-reload on expiry under
// the COUNTDOWN_AUTO_RELOAD_EN macro.
module countdown_timer
  import timer_pkg::*;
#(
  parameter logic [FIELD_W-1:0] HOURS_MAX = 7'd23
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               pause,
  input  logic               load,
  input  logic               start,
  input  logic [FIELD_W-1:0] load_hours,
  input  logic [FIELD_W-1:0] load_minutes,
  input  logic [FIELD_W-1:0] load_seconds,
  output logic [FIELD_W-1:0] hours_counter,
  output logic [FIELD_W-1:0] minutes_counter,
  output logic [FIELD_W-1:0] seconds_counter,
  output logic               running,
  output logic               expired,
  output logic               expired_pulse,
  output logic [1:0]         dbg_state
);

  state_e             state, state_n;
  logic [FIELD_W-1:0] h_n, m_n, s_n;
  logic [FIELD_W-1:0] h_dec, m_dec, s_dec;
  logic               dec_zero;
  logic               count_zero;
  logic               pulse_n;
  logic               running_n;

  hms_decrement u_dec (
    .h       (hours_counter),
    .m       (minutes_counter),
    .s       (seconds_counter),
    .h_next  (h_dec),
    .m_next  (m_dec),
    .s_next  (s_dec),
    .is_zero (dec_zero)
  );

  assign count_zero = (hours_counter == '0) && (minutes_counter == '0) && (seconds_counter == '0);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic [FIELD_W-1:0] rl_h, rl_m, rl_s;
  logic               reload_nonzero;
  assign reload_nonzero = (rl_h != '0) || (rl_m != '0) || (rl_s != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rl_h <= '0;
      rl_m <= '0;
      rl_s <= '0;
    end else if (load) begin
      rl_h <= clamp_field(load_hours, HOURS_MAX);
      rl_m <= clamp_field(load_minutes, MIN_MAX);
      rl_s <= clamp_field(load_seconds, SEC_MAX);
    end
  end
`endif

  // Priority: load > start (IDLE only) > tick (RUN, unpaused).
  always_comb begin
    state_n = state;
    h_n     = hours_counter;
    m_n     = minutes_counter;
    s_n     = seconds_counter;
    pulse_n = 1'b0;
    if (load) begin
      state_n = IDLE;
      h_n     = clamp_field(load_hours, HOURS_MAX);
      m_n     = clamp_field(load_minutes, MIN_MAX);
      s_n     = clamp_field(load_seconds, SEC_MAX);
    end else if (start && state == IDLE) begin
      if (count_zero) begin
        state_n = EXPIRED;
        pulse_n = 1'b1;
      end else begin
        state_n = RUN;
      end
    end else if (state == RUN && tick && !pause) begin
      h_n = h_dec;
      m_n = m_dec;
      s_n = s_dec;
      if (dec_zero) begin
        pulse_n = 1'b1;
        state_n = EXPIRED;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        if (reload_nonzero) begin
          state_n = RUN;
          h_n     = rl_h;
          m_n     = rl_m;
          s_n     = rl_s;
        end
`endif
      end
    end
    running_n = (state_n == RUN) && !pause;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      hours_counter   <= '0;
      minutes_counter <= '0;
      seconds_counter <= '0;
      expired_pulse   <= 1'b0;
      running         <= 1'b0;
    end else begin
      state           <= state_n;
      hours_counter   <= h_n;
      minutes_counter <= m_n;
      seconds_counter <= s_n;
      expired_pulse   <= pulse_n;
      running         <= running_n;
    end
  end

  assign expired   = (state == EXPIRED);
  assign dbg_state = state;

endmodule
